id_ex_stage: RTL and testbench
==============================

# id_ex_stage

Pipeline stage directly upstream of the ALU: registers one decoded instruction per cycle (operands, immediate, destination, 4-bit ALU control) and drives the ALU operand/control inputs. Resolves RAW hazards by forwarding from the MEM and WB stages. Uses a valid/ready handshake with stall and flush. Refreshes held operands while stalled so forwarded values are never lost.

## Interface
- DATA_W, 32, operand/result width
- REG_AW, 5, register-address width
- CTRL_W, 4, ALU control width
- clk_i  in  1  clock, rising edge
- rst_i  in  1  reset, asynchronous, active-low
- id_valid_i  in  1  decode offers an instruction
- id_ready_o  out  1  stage can accept this cycle
- id_rs_data_i / id_rt_data_i  in  DATA_W  register-file read data
- id_imm_i  in  DATA_W  sign-extended immediate
- id_rs_addr_i / id_rt_addr_i / id_rd_addr_i  in  REG_AW  source and destination registers
- id_alu_ctrl_i  in  CTRL_W  ALU operation code
- id_alu_src_i  in  1  1 = src2 is the immediate
- id_reg_write_i  in  1  instruction writes rd
- flush_i  in  1  kill held and incoming instruction
- ex_ready_i  in  1  EX/MEM accepts the current instruction
- mem_reg_write_i, mem_rd_addr_i, mem_result_i  in  1/REG_AW/DATA_W  MEM-stage writeback candidate
- wb_reg_write_i, wb_rd_addr_i, wb_result_i  in  1/REG_AW/DATA_W  WB-stage writeback candidate
- ex_valid_o  out  1  ALU inputs hold a live instruction
- alu_src1_o / alu_src2_o  out  DATA_W  ALU operands
- alu_ctrl_o  out  CTRL_W  ALU control
- ex_rt_data_o  out  DATA_W  forwarded rt (store data)
- ex_rd_addr_o  out  REG_AW; ex_reg_write_o  out  1  destination passed downstream

## Operation
- Registered fields: valid, rs_val, rt_val, imm, rs_addr, rt_addr, rd_addr, alu_ctrl, alu_src, reg_write.
- id_ready_o = !ex_valid_o || ex_ready_i. Registers load on id_valid_i && id_ready_o. Otherwise valid clears when ex_ready_i=1, and holds when ex_ready_i=0.
- Forwarding is combinational on the registered values.
- fwd(addr, val) returns:
  - mem_result_i if mem_reg_write_i && mem_rd_addr_i==addr && addr!=0;
  - else wb_result_i if wb_reg_write_i && wb_rd_addr_i==addr && addr!=0;
  - else val.
- MEM has priority over WB. Register 0 is never forwarded.
- alu_src1_o = fwd(rs). ex_rt_data_o = fwd(rt). alu_src2_o = alu_src ? imm : fwd(rt).
- Held refresh: while ex_valid_o && !ex_ready_i, rs_val/rt_val reload with fwd(rs)/fwd(rt) each edge. This keeps a producer that retires during the stall.
- Flush:
  - Next edge, valid=0 and reg_write=0; the incoming instruction is dropped.
  - flush_i beats both capture and hold.
  - id_ready_o is unaffected by flush_i.
- ex_reg_write_o = reg_write && valid. Destination outputs never show a write from a bubble.
- alu_ctrl_o passes through unmodified. Codes: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, others SLT.

## Timing
- Latency 1 cycle: accepted at edge N, visible on the outputs after edge N.
- Throughput: one per cycle when ex_ready_i=1.
- Reset, asynchronous, on rst_i=0:
  - all registers 0, so ex_valid_o=0, alu_ctrl_o=0, ex_rd_addr_o=0, ex_reg_write_o=0, id_ready_o=1;
  - operand outputs equal the forwarded value of register 0 with a zero register, i.e. 0.
- Reset mid-stall discards the held instruction. Reset release is synchronous to clk_i.
- Simultaneous accept and drain (ex_ready_i=1, id_valid_i=1): the new instruction replaces the old at that edge with no bubble.
- The handshake does not depend combinationally on id_valid_i. id_ready_o depends only on ex_valid_o and ex_ready_i.

## Structure
- Shared package alu_pkg holds:
  - ALU control code constants (AND, OR, ADD, SUB, SLT);
  - DATA_W, REG_AW, CTRL_W defaults;
  - REG_ZERO.
- One sub-module, fwd_unit: pure combinational priority select for one operand. It is instantiated twice, for rs and rt.
- The top module holds the pipeline registers and the handshake.

## Test plan
- Reset then pass-through: rs=r1=5, rt=r2=3, ADD (0010), ex_ready=1.
  - Cycle after accept: alu_src1=5, alu_src2=3, alu_ctrl=0010, ex_valid=1.
- Forward priority: held rs=r4, mem writes r4=0xAA, wb writes r4=0xBB.
  - alu_src1=0xAA. With mem_reg_write=0, alu_src1=0xBB.
  - With rs=r0 and all forwarding sources active, alu_src1 stays at the r0 read value.
- Stall refresh: ex_ready=0, mem forwards r4=7 for one cycle, then drops.
  - alu_src1 stays 7 until ex_ready=1.
  - id_ready=0 throughout the stall.
- Immediate select: alu_src=1, imm=0xFFFFFFFC, rt forwarded=9.
  - alu_src2=0xFFFFFFFC and ex_rt_data=9.
- Flush during stall with id_valid=1: next cycle ex_valid=0 and ex_reg_write=0; the incoming instruction does not appear.
- Async reset mid-stream: rst_i low between edges.
  - Outputs go to 0 immediately. After release, the first accepted instruction appears 1 cycle later.

Source files
------------

// File: rtl/alu_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | alu_pkg: shared ALU control codes, datapath widths, zero register    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package alu_pkg;

    localparam int unsigned DEF_DATA_W = 32;
    localparam int unsigned DEF_REG_AW = 5;
    localparam int unsigned DEF_CTRL_W = 4;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;

    // Hard-wired zero register: never a forwarding target.
    localparam int unsigned REG_ZERO = 0;

endpackage
`default_nettype wire

// File: rtl/fwd_unit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fwd_unit: MEM-over-WB priority bypass select for one source operand  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module fwd_unit
    import alu_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int REG_AW = DEF_REG_AW
) (
    input  logic [REG_AW-1:0] addr_i,
    input  logic [DATA_W-1:0] val_i,
    input  logic              mem_reg_write_i,
    input  logic [REG_AW-1:0] mem_rd_addr_i,
    input  logic [DATA_W-1:0] mem_result_i,
    input  logic              wb_reg_write_i,
    input  logic [REG_AW-1:0] wb_rd_addr_i,
    input  logic [DATA_W-1:0] wb_result_i,
    output logic [DATA_W-1:0] data_o
);

    logic w_nonzero;
    logic w_mem_hit;
    logic w_wb_hit;

    assign w_nonzero = (addr_i != REG_AW'(REG_ZERO));
    assign w_mem_hit = w_nonzero && mem_reg_write_i && (mem_rd_addr_i == addr_i);
    assign w_wb_hit  = w_nonzero && wb_reg_write_i  && (wb_rd_addr_i  == addr_i);

    always_comb begin
        data_o = val_i;
        if (w_mem_hit) begin
            data_o = mem_result_i;
        end else if (w_wb_hit) begin
            data_o = wb_result_i;
        end
    end

endmodule
`default_nettype wire

// File: rtl/id_ex_stage.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | id_ex_stage: ID/EX pipeline register with handshake, flush and       |
// | MEM/WB operand forwarding into the ALU                               |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module id_ex_stage
    import alu_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int REG_AW = DEF_REG_AW,
    parameter int CTRL_W = DEF_CTRL_W
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              id_valid_i,
    output logic              id_ready_o,
    input  logic [DATA_W-1:0] id_rs_data_i,
    input  logic [DATA_W-1:0] id_rt_data_i,
    input  logic [DATA_W-1:0] id_imm_i,
    input  logic [REG_AW-1:0] id_rs_addr_i,
    input  logic [REG_AW-1:0] id_rt_addr_i,
    input  logic [REG_AW-1:0] id_rd_addr_i,
    input  logic [CTRL_W-1:0] id_alu_ctrl_i,
    input  logic              id_alu_src_i,
    input  logic              id_reg_write_i,
    input  logic              flush_i,
    input  logic              ex_ready_i,
    input  logic              mem_reg_write_i,
    input  logic [REG_AW-1:0] mem_rd_addr_i,
    input  logic [DATA_W-1:0] mem_result_i,
    input  logic              wb_reg_write_i,
    input  logic [REG_AW-1:0] wb_rd_addr_i,
    input  logic [DATA_W-1:0] wb_result_i,
    output logic              ex_valid_o,
    output logic [DATA_W-1:0] alu_src1_o,
    output logic [DATA_W-1:0] alu_src2_o,
    output logic [CTRL_W-1:0] alu_ctrl_o,
    output logic [DATA_W-1:0] ex_rt_data_o,
    output logic [REG_AW-1:0] ex_rd_addr_o,
    output logic              ex_reg_write_o
);

    logic              valid_q,     valid_d;
    logic [DATA_W-1:0] rs_val_q,    rs_val_d;
    logic [DATA_W-1:0] rt_val_q,    rt_val_d;
    logic [DATA_W-1:0] imm_q,       imm_d;
    logic [REG_AW-1:0] rs_addr_q,   rs_addr_d;
    logic [REG_AW-1:0] rt_addr_q,   rt_addr_d;
    logic [REG_AW-1:0] rd_addr_q,   rd_addr_d;
    logic [CTRL_W-1:0] alu_ctrl_q,  alu_ctrl_d;
    logic              alu_src_q,   alu_src_d;
    logic              reg_write_q, reg_write_d;

    logic [DATA_W-1:0] w_rs_fwd;
    logic [DATA_W-1:0] w_rt_fwd;
    logic              w_load;
    logic              w_hold;

    fwd_unit #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_fwd_rs (
        .addr_i          (rs_addr_q),
        .val_i           (rs_val_q),
        .mem_reg_write_i (mem_reg_write_i),
        .mem_rd_addr_i   (mem_rd_addr_i),
        .mem_result_i    (mem_result_i),
        .wb_reg_write_i  (wb_reg_write_i),
        .wb_rd_addr_i    (wb_rd_addr_i),
        .wb_result_i     (wb_result_i),
        .data_o          (w_rs_fwd)
    );

    fwd_unit #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_fwd_rt (
        .addr_i          (rt_addr_q),
        .val_i           (rt_val_q),
        .mem_reg_write_i (mem_reg_write_i),
        .mem_rd_addr_i   (mem_rd_addr_i),
        .mem_result_i    (mem_result_i),
        .wb_reg_write_i  (wb_reg_write_i),
        .wb_rd_addr_i    (wb_rd_addr_i),
        .wb_result_i     (wb_result_i),
        .data_o          (w_rt_fwd)
    );

    assign id_ready_o = !valid_q || ex_ready_i;
    assign w_load     = id_valid_i && id_ready_o;
    assign w_hold     = valid_q && !ex_ready_i;

    always_comb begin
        valid_d     = valid_q;
        rs_val_d    = rs_val_q;
        rt_val_d    = rt_val_q;
        imm_d       = imm_q;
        rs_addr_d   = rs_addr_q;
        rt_addr_d   = rt_addr_q;
        rd_addr_d   = rd_addr_q;
        alu_ctrl_d  = alu_ctrl_q;
        alu_src_d   = alu_src_q;
        reg_write_d = reg_write_q;
        if (flush_i) begin
            valid_d     = 1'b0;
            reg_write_d = 1'b0;
        end else if (w_load) begin
            valid_d     = 1'b1;
            rs_val_d    = id_rs_data_i;
            rt_val_d    = id_rt_data_i;
            imm_d       = id_imm_i;
            rs_addr_d   = id_rs_addr_i;
            rt_addr_d   = id_rt_addr_i;
            rd_addr_d   = id_rd_addr_i;
            alu_ctrl_d  = id_alu_ctrl_i;
            alu_src_d   = id_alu_src_i;
            reg_write_d = id_reg_write_i;
        end else if (w_hold) begin
            // Capture bypassed values so a producer retiring mid-stall is not lost.
            rs_val_d = w_rs_fwd;
            rt_val_d = w_rt_fwd;
        end else begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            valid_q     <= 1'b0;
            rs_val_q    <= '0;
            rt_val_q    <= '0;
            imm_q       <= '0;
            rs_addr_q   <= '0;
            rt_addr_q   <= '0;
            rd_addr_q   <= '0;
            alu_ctrl_q  <= '0;
            alu_src_q   <= 1'b0;
            reg_write_q <= 1'b0;
        end else begin
            valid_q     <= valid_d;
            rs_val_q    <= rs_val_d;
            rt_val_q    <= rt_val_d;
            imm_q       <= imm_d;
            rs_addr_q   <= rs_addr_d;
            rt_addr_q   <= rt_addr_d;
            rd_addr_q   <= rd_addr_d;
            alu_ctrl_q  <= alu_ctrl_d;
            alu_src_q   <= alu_src_d;
            reg_write_q <= reg_write_d;
        end
    end

    assign ex_valid_o     = valid_q;
    assign alu_src1_o     = w_rs_fwd;
    assign alu_src2_o     = alu_src_q ? imm_q : w_rt_fwd;
    assign ex_rt_data_o   = w_rt_fwd;
    assign alu_ctrl_o     = alu_ctrl_q;
    assign ex_rd_addr_o   = rd_addr_q;
    assign ex_reg_write_o = reg_write_q && valid_q;

endmodule
`default_nettype wire

// File: tb/tb_id_ex_stage.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_id_ex_stage: vector table, reset sequence and random model check  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_id_ex_stage;
    import alu_pkg::*;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        id_valid_i, id_ready_o;
    logic [31:0] id_rs_data_i, id_rt_data_i, id_imm_i;
    logic [4:0]  id_rs_addr_i, id_rt_addr_i, id_rd_addr_i;
    logic [3:0]  id_alu_ctrl_i;
    logic        id_alu_src_i, id_reg_write_i, flush_i, ex_ready_i;
    logic        mem_reg_write_i, wb_reg_write_i;
    logic [4:0]  mem_rd_addr_i, wb_rd_addr_i;
    logic [31:0] mem_result_i, wb_result_i;
    logic        ex_valid_o, ex_reg_write_o;
    logic [31:0] alu_src1_o, alu_src2_o, ex_rt_data_o;
    logic [3:0]  alu_ctrl_o;
    logic [4:0]  ex_rd_addr_o;

    int checks = 0;
    int errors = 0;

    always #5 clk_i = ~clk_i;

    id_ex_stage dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .id_valid_i(id_valid_i), .id_ready_o(id_ready_o),
        .id_rs_data_i(id_rs_data_i), .id_rt_data_i(id_rt_data_i), .id_imm_i(id_imm_i),
        .id_rs_addr_i(id_rs_addr_i), .id_rt_addr_i(id_rt_addr_i), .id_rd_addr_i(id_rd_addr_i),
        .id_alu_ctrl_i(id_alu_ctrl_i), .id_alu_src_i(id_alu_src_i), .id_reg_write_i(id_reg_write_i),
        .flush_i(flush_i), .ex_ready_i(ex_ready_i),
        .mem_reg_write_i(mem_reg_write_i), .mem_rd_addr_i(mem_rd_addr_i), .mem_result_i(mem_result_i),
        .wb_reg_write_i(wb_reg_write_i), .wb_rd_addr_i(wb_rd_addr_i), .wb_result_i(wb_result_i),
        .ex_valid_o(ex_valid_o), .alu_src1_o(alu_src1_o), .alu_src2_o(alu_src2_o),
        .alu_ctrl_o(alu_ctrl_o), .ex_rt_data_o(ex_rt_data_o),
        .ex_rd_addr_o(ex_rd_addr_o), .ex_reg_write_o(ex_reg_write_o)
    );

    typedef struct {
        logic idv; logic [4:0] rs, rt, rd; logic [31:0] rsd, rtd, imm; logic [3:0] ctrl;
        logic asrc, rw, flush, exr;
        logic mw; logic [4:0] ma; logic [31:0] md;
        logic ww; logic [4:0] wa; logic [31:0] wd;
        logic e_v, e_rdy; logic [31:0] e_s1, e_s2, e_rt; logic [3:0] e_ctrl; logic [4:0] e_rd; logic e_rw;
    } vec_t;

    // Instruction currently held by the stage, as the reference model sees it.
    typedef struct {
        logic v; logic [4:0] rs, rt, rd; logic [31:0] rsv, rtv, imm; logic [3:0] ctrl; logic src, rw;
    } held_t;

    vec_t  tbl [10];
    held_t m;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic cmp_outs(input string tag, input logic e_v, input logic e_rdy,
                            input logic [31:0] e_s1, input logic [31:0] e_s2, input logic [31:0] e_rt,
                            input logic [3:0] e_ctrl, input logic [4:0] e_rd, input logic e_rw);
        chk({tag, ".ex_valid"}, 32'(ex_valid_o), 32'(e_v));
        chk({tag, ".id_ready"}, 32'(id_ready_o), 32'(e_rdy));
        chk({tag, ".src1"}, alu_src1_o, e_s1);
        chk({tag, ".src2"}, alu_src2_o, e_s2);
        chk({tag, ".rt_data"}, ex_rt_data_o, e_rt);
        chk({tag, ".ctrl"}, 32'(alu_ctrl_o), 32'(e_ctrl));
        chk({tag, ".rd"}, 32'(ex_rd_addr_o), 32'(e_rd));
        chk({tag, ".reg_write"}, 32'(ex_reg_write_o), 32'(e_rw));
    endtask

    task automatic drive(input vec_t v);
        id_valid_i = v.idv; id_rs_addr_i = v.rs; id_rt_addr_i = v.rt; id_rd_addr_i = v.rd;
        id_rs_data_i = v.rsd; id_rt_data_i = v.rtd; id_imm_i = v.imm; id_alu_ctrl_i = v.ctrl;
        id_alu_src_i = v.asrc; id_reg_write_i = v.rw; flush_i = v.flush; ex_ready_i = v.exr;
        mem_reg_write_i = v.mw; mem_rd_addr_i = v.ma; mem_result_i = v.md;
        wb_reg_write_i = v.ww; wb_rd_addr_i = v.wa; wb_result_i = v.wd;
    endtask

    task automatic idle_inputs();
        vec_t z;
        z = '{1'b0, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b1,
              1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0,
              1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 4'h0, 5'd0, 1'b0};
        drive(z);
    endtask

    // Bypass: the first active source (in priority order) naming a non-zero register wins.
    function automatic logic [31:0] ref_fwd(input logic [4:0] addr, input logic [31:0] val);
        logic        we [2];
        logic [4:0]  a  [2];
        logic [31:0] d  [2];
        we[0] = mem_reg_write_i; a[0] = mem_rd_addr_i; d[0] = mem_result_i;
        we[1] = wb_reg_write_i;  a[1] = wb_rd_addr_i;  d[1] = wb_result_i;
        if (addr == 5'd0) return val;
        for (int i = 0; i < 2; i++) if (we[i] && a[i] == addr) return d[i];
        return val;
    endfunction

    task automatic model_check(input string tag);
        logic [31:0] rtf;
        rtf = ref_fwd(m.rt, m.rtv);
        cmp_outs(tag, m.v, !m.v || ex_ready_i, ref_fwd(m.rs, m.rsv), m.src ? m.imm : rtf, rtf,
                 m.ctrl, m.rd, m.v && m.rw);
    endtask

    task automatic model_step();
        logic accept;
        accept = id_valid_i && (!m.v || ex_ready_i);
        if (flush_i) begin
            m.v = 1'b0; m.rw = 1'b0;
        end else if (accept) begin
            m = '{1'b1, id_rs_addr_i, id_rt_addr_i, id_rd_addr_i, id_rs_data_i, id_rt_data_i,
                  id_imm_i, id_alu_ctrl_i, id_alu_src_i, id_reg_write_i};
        end else if (m.v && !ex_ready_i) begin
            m.rsv = ref_fwd(m.rs, m.rsv);
            m.rtv = ref_fwd(m.rt, m.rtv);
        end else begin
            m.v = 1'b0;
        end
    endtask

    task automatic rand_inputs();
        id_valid_i = 1'($urandom_range(0, 1));
        id_rs_addr_i = 5'($urandom_range(0, 3)); id_rt_addr_i = 5'($urandom_range(0, 3));
        id_rd_addr_i = 5'($urandom_range(0, 31));
        id_rs_data_i = $urandom; id_rt_data_i = $urandom; id_imm_i = $urandom;
        id_alu_ctrl_i = 4'($urandom_range(0, 15)); id_alu_src_i = 1'($urandom_range(0, 1));
        id_reg_write_i = 1'($urandom_range(0, 1));
        flush_i = ($urandom_range(0, 15) == 0);
        ex_ready_i = ($urandom_range(0, 3) != 0);
        mem_reg_write_i = 1'($urandom_range(0, 1)); mem_rd_addr_i = 5'($urandom_range(0, 3));
        mem_result_i = $urandom;
        wb_reg_write_i = 1'($urandom_range(0, 1)); wb_rd_addr_i = 5'($urandom_range(0, 3));
        wb_result_i = $urandom;
    endtask

    initial begin
        // Each row: inputs applied this cycle, outputs expected this cycle (before the next edge).
        tbl[0] = '{1'b1, 5'd1, 5'd2, 5'd3, 32'h5, 32'h3, 32'h0, ALU_ADD, 1'b0, 1'b1, 1'b0, 1'b1,
                   1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0,
                   1'b0, 1'b1, 32'h0, 32'h0, 32'h0, 4'h0, 5'd0, 1'b0};
        tbl[1] = '{1'b0, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b1,
                   1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0,
                   1'b1, 1'b1, 32'h5, 32'h3, 32'h3, ALU_ADD, 5'd3, 1'b1};
        tbl[2] = '{1'b1, 5'd4, 5'd5, 5'd6, 32'h1, 32'h2, 32'h0, ALU_SUB, 1'b0, 1'b1, 1'b0, 1'b1,
                   1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0,
                   1'b0, 1'b1, 32'h5, 32'h3, 32'h3, ALU_ADD, 5'd3, 1'b0};
        tbl[3] = '{1'b0, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0,
                   1'b1, 5'd4, 32'hAA, 1'b1, 5'd4, 32'hBB,
                   1'b1, 1'b0, 32'hAA, 32'h2, 32'h2, ALU_SUB, 5'd6, 1'b1};
        tbl[4] = '{1'b0, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0,
                   1'b0, 5'd4, 32'hAA, 1'b1, 5'd4, 32'hBB,
                   1'b1, 1'b0, 32'hBB, 32'h2, 32'h2, ALU_SUB, 5'd6, 1'b1};
        tbl[5] = '{1'b0, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0,
                   1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0,
                   1'b1, 1'b0, 32'hBB, 32'h2, 32'h2, ALU_SUB, 5'd6, 1'b1};
        tbl[6] = '{1'b1, 5'd0, 5'd5, 5'd7, 32'h11, 32'h22, 32'hFFFFFFFC, ALU_SLT, 1'b1, 1'b1, 1'b0, 1'b1,
                   1'b1, 5'd5, 32'h9, 1'b0, 5'd0, 32'h0,
                   1'b1, 1'b1, 32'hBB, 32'h9, 32'h9, ALU_SUB, 5'd6, 1'b1};
        tbl[7] = '{1'b0, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0,
                   1'b1, 5'd0, 32'hDEAD, 1'b1, 5'd5, 32'h9,
                   1'b1, 1'b0, 32'h11, 32'hFFFFFFFC, 32'h9, ALU_SLT, 5'd7, 1'b1};
        tbl[8] = '{1'b1, 5'd1, 5'd2, 5'd9, 32'h55, 32'h66, 32'h0, ALU_OR, 1'b0, 1'b1, 1'b1, 1'b0,
                   1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0,
                   1'b1, 1'b0, 32'h11, 32'hFFFFFFFC, 32'h9, ALU_SLT, 5'd7, 1'b1};
        tbl[9] = '{1'b0, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0,
                   1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0,
                   1'b0, 1'b1, 32'h11, 32'hFFFFFFFC, 32'h9, ALU_SLT, 5'd7, 1'b0};

        rst_i = 1'b0;
        idle_inputs();
        repeat (2) @(posedge clk_i);
        #1;
        cmp_outs("reset", 1'b0, 1'b1, 32'h0, 32'h0, 32'h0, 4'h0, 5'd0, 1'b0);
        rst_i = 1'b1;

        for (int i = 0; i < 10; i++) begin
            drive(tbl[i]);
            #2;
            cmp_outs($sformatf("vec%0d", i), tbl[i].e_v, tbl[i].e_rdy, tbl[i].e_s1, tbl[i].e_s2,
                     tbl[i].e_rt, tbl[i].e_ctrl, tbl[i].e_rd, tbl[i].e_rw);
            @(posedge clk_i);
            #1;
        end

        // Asynchronous reset while an instruction is stalled.
        idle_inputs();
        id_valid_i = 1'b1; id_rs_addr_i = 5'd1; id_rt_addr_i = 5'd2; id_rd_addr_i = 5'd4;
        id_rs_data_i = 32'h10; id_rt_data_i = 32'h20; id_alu_ctrl_i = ALU_ADD; id_reg_write_i = 1'b1;
        @(posedge clk_i);
        #1;
        idle_inputs();
        ex_ready_i = 1'b0;
        #2;
        cmp_outs("prerst", 1'b1, 1'b0, 32'h10, 32'h20, 32'h20, ALU_ADD, 5'd4, 1'b1);
        rst_i = 1'b0;
        #1;
        cmp_outs("rst_async", 1'b0, 1'b1, 32'h0, 32'h0, 32'h0, 4'h0, 5'd0, 1'b0);
        @(posedge clk_i);
        #1;
        rst_i = 1'b1;
        id_valid_i = 1'b1; ex_ready_i = 1'b1; id_rs_addr_i = 5'd1; id_rt_addr_i = 5'd2;
        id_rd_addr_i = 5'd5; id_rs_data_i = 32'h77; id_rt_data_i = 32'h88;
        id_alu_ctrl_i = ALU_SUB; id_reg_write_i = 1'b1;
        #2;
        cmp_outs("rst_rel", 1'b0, 1'b1, 32'h0, 32'h0, 32'h0, 4'h0, 5'd0, 1'b0);
        @(posedge clk_i);
        #1;
        idle_inputs();
        #2;
        cmp_outs("rst_first", 1'b1, 1'b1, 32'h77, 32'h88, 32'h88, ALU_SUB, 5'd5, 1'b1);

        // Randomized traffic against the reference model, starting from reset.
        rst_i = 1'b0;
        @(posedge clk_i);
        #1;
        rst_i = 1'b1;
        m = '{1'b0, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0};
        for (int c = 0; c < 400; c++) begin
            rand_inputs();
            #2;
            model_check($sformatf("rnd%0d", c));
            model_step();
            @(posedge clk_i);
            #1;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
